receive_capture_to_mem: RTL and testbench

- Inverse of the capture sender: takes the octet stream from the UART receiver and rebuilds LA memory words, LSB octet first.
- Writes each word into a capture memory through port A, starting at LAST_ADDR and descending to FIRST_ADDR. This matches the sender's transmit order, so a loopback reproduces the original memory image.
- Sits between the UART RX and the dual-port capture RAM on the host/emulation side. Started with a run/ack handshake and ends with a done pulse.

---
 rtl/receive_capture_to_mem.sv | 138 +++++++++++++
 tb/tb_receive_capture_to_mem.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/receive_capture_to_mem.sv
// receive_capture_to_mem: rebuilds capture-memory words from a received
// octet stream (LSB octet first) and writes them through RAM port A,
// walking from MEM_LAST_ADDR down to MEM_FIRST_ADDR, so that a loopback
// against the capture sender reproduces the original memory image.
//
// Handshakes: rc_run is a level request taken only in IDLE and answered by
// a one-clk ack_rc_run; rx_validH is a one-clk strobe that qualifies
// rx_dataH and has no back-pressure; octets that arrive while the block
// cannot accept them are dropped and flagged in rc_overrun_err.
module receive_capture_to_mem #(
    parameter int MEM_ADDRESS_BITS   = 8,
    parameter int MEM_WORDLEN_BITS   = 32,
    parameter int MEM_WORDLEN_OCTETS = 4,
    parameter int MEM_FIRST_ADDR     = 0,
    parameter int MEM_LAST_ADDR      = 255,
    parameter int TIMEOUT_CYCLES     = 1000000
) (
    input  logic                        clk,
    input  logic                        rst_l,
    input  logic                        rc_run,
    input  logic                        rc_abort,
    input  logic [7:0]                  rx_dataH,
    input  logic                        rx_validH,
    output logic                        ack_rc_run,
    output logic                        rc_done,
    output logic [MEM_ADDRESS_BITS-1:0] mem_port_A_address,
    output logic [MEM_WORDLEN_BITS-1:0] mem_port_A_din,
    output logic                        mem_port_A_we,
    output logic                        rc_timeout_err,
    output logic                        rc_overrun_err,
    output logic [2:0]                  rc_state
);

    localparam int OID_W = (MEM_WORDLEN_OCTETS > 1) ? $clog2(MEM_WORDLEN_OCTETS) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACK   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                      state;
    logic [MEM_ADDRESS_BITS-1:0] cur_addr;
    logic [MEM_WORDLEN_BITS-1:0] word;
    logic [OID_W-1:0]            octet_id;
    logic [CNT_W-1:0]            tmo_cnt;
    logic                        state_legal;

    // Control FSM: word assembly, inter-octet timeout, address walk, error flags.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state          <= ST_IDLE;
            cur_addr       <= '0;
            word           <= '0;
            octet_id       <= '0;
            tmo_cnt        <= '0;
            rc_timeout_err <= 1'b0;
            rc_overrun_err <= 1'b0;
        end else if (rc_abort) begin
            // Abort beats everything; error flags stay for the host to read.
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    rc_timeout_err <= 1'b0;
                    rc_overrun_err <= 1'b0;
                    if (rc_run) begin
                        state    <= ST_ACK;
                        cur_addr <= MEM_ADDRESS_BITS'(MEM_LAST_ADDR);
                        word     <= '0;
                        octet_id <= '0;
                        tmo_cnt  <= '0;
                    end
                end
                ST_ACK: begin
                    if (rx_validH) rc_overrun_err <= 1'b1;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (rx_validH) begin
                        // A strobe wins over a coinciding timeout terminal count.
                        word[8*octet_id +: 8] <= rx_dataH;
                        tmo_cnt               <= '0;
                        if (octet_id == OID_W'(MEM_WORDLEN_OCTETS - 1)) begin
                            octet_id <= '0;
                            state    <= ST_WRITE;
                        end else begin
                            octet_id <= octet_id + 1'b1;
                        end
                    end else if (octet_id != '0) begin
                        if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                            // Stale partial word: discard it and resync on the next octet.
                            word           <= '0;
                            octet_id       <= '0;
                            tmo_cnt        <= '0;
                            rc_timeout_err <= 1'b1;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (rx_validH) rc_overrun_err <= 1'b1;
                    if (cur_addr > MEM_ADDRESS_BITS'(MEM_FIRST_ADDR)) begin
                        cur_addr <= cur_addr - 1'b1;
                        word     <= '0;
                        octet_id <= '0;
                        tmo_cnt  <= '0;
                        state    <= ST_WAIT;
                    end else begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (rx_validH) rc_overrun_err <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Moore output decode from registered state only.
    always_comb begin
        state_legal = (state == ST_IDLE) || (state == ST_ACK) || (state == ST_WAIT) ||
                      (state == ST_WRITE) || (state == ST_DONE);
        ack_rc_run         = (state == ST_ACK);
        rc_done            = (state == ST_DONE);
        mem_port_A_we      = (state == ST_WRITE);
        mem_port_A_din     = (state == ST_WRITE) ? word : '0;
        mem_port_A_address = state_legal ? cur_addr : '0;
        rc_state           = state;
    end

endmodule

// File: tb/tb_receive_capture_to_mem.sv
// Bench for receive_capture_to_mem: handshake, full run, timeout, overrun,
// abort and mid-word reset, with a write scoreboard fed by the octet driver.
module tb_receive_capture_to_mem;

    localparam int AB = 3;
    localparam int WB = 16;

    logic          clk = 1'b0;
    logic          rst_l = 1'b0;
    logic          rc_run = 1'b0;
    logic          rc_abort = 1'b0;
    logic [7:0]    rx_dataH = 8'h00;
    logic          rx_validH = 1'b0;
    logic          ack_rc_run;
    logic          rc_done;
    logic [AB-1:0] mem_port_A_address;
    logic [WB-1:0] mem_port_A_din;
    logic          mem_port_A_we;
    logic          rc_timeout_err;
    logic          rc_overrun_err;
    logic [2:0]    rc_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [AB+WB-1:0] exp_q[$];
    logic done_ok = 1'b0;

    receive_capture_to_mem #(
        .MEM_ADDRESS_BITS(AB), .MEM_WORDLEN_BITS(WB), .MEM_WORDLEN_OCTETS(2),
        .MEM_FIRST_ADDR(0), .MEM_LAST_ADDR(7), .TIMEOUT_CYCLES(20)
    ) dut (
        .clk(clk), .rst_l(rst_l), .rc_run(rc_run), .rc_abort(rc_abort),
        .rx_dataH(rx_dataH), .rx_validH(rx_validH), .ack_rc_run(ack_rc_run),
        .rc_done(rc_done), .mem_port_A_address(mem_port_A_address),
        .mem_port_A_din(mem_port_A_din), .mem_port_A_we(mem_port_A_we),
        .rc_timeout_err(rc_timeout_err), .rc_overrun_err(rc_overrun_err),
        .rc_state(rc_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_octet(input logic [7:0] d);
        @(negedge clk);
        rx_dataH  = d;
        rx_validH = 1'b1;
        @(negedge clk);
        rx_validH = 1'b0;
    endtask

    task automatic start_run();
        @(negedge clk);
        rc_run = 1'b1;
        @(negedge clk);
        rc_run = 1'b0;
        check("ack_high", 32'(ack_rc_run), 32'd1);
        @(negedge clk);
        check("ack_low", 32'(ack_rc_run), 32'd0);
        check("run_addr", 32'(mem_port_A_address), 32'd7);
        check("run_state_wait", 32'(rc_state), 32'd2);
    endtask

    // Low octet, 12 clks gap, then the completing octet; ends in the WRITE cycle.
    task automatic send_word(input logic [7:0] lo, input logic [7:0] hi, input logic [AB-1:0] addr);
        send_octet(lo);
        idle(11);
        exp_q.push_back({addr, hi, lo});
        send_octet(hi);
    endtask

    // Scoreboard: every write must match the head of the expected queue.
    always @(negedge clk) begin
        if (mem_port_A_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {13'd0, mem_port_A_address, mem_port_A_din}, 32'hFFFF_FFFF);
            end else begin
                check("write", {13'd0, mem_port_A_address, mem_port_A_din}, {13'd0, exp_q.pop_front()});
            end
        end
        if (rc_done) check("done_allowed", 32'(done_ok), 32'd1);
    end

    initial begin
        logic done_seen;
        #1;
        check("reset_outputs", {ack_rc_run, rc_done, mem_port_A_we, mem_port_A_address, mem_port_A_din,
                                rc_timeout_err, rc_overrun_err}, 32'd0);
        check("reset_state", 32'(rc_state), 32'd0);
        idle(2);
        rst_l = 1'b1;
        idle(2);

        // Full run: eight words, addr 7 down to 0
        start_run();
        for (int k = 1; k <= 8; k++) begin
            if (k == 8) done_ok = 1'b1;
            send_word(8'(k), 8'(k << 4), AB'(8 - k));
            if (k < 8) idle(11);
        end
        check("full_errs", {rc_timeout_err, rc_overrun_err}, 32'd0);
        @(negedge clk);
        check("full_done", 32'(rc_done), 32'd1);
        @(negedge clk);
        done_ok = 1'b0;
        check("full_done_low", 32'(rc_done), 32'd0);
        check("full_idle", 32'(rc_state), 32'd0);
        check("full_queue_empty", exp_q.size(), 32'd0);

        // Timeout: one octet then silence
        start_run();
        send_octet(8'hAA);
        idle(19);
        check("tmo_not_yet", 32'(rc_timeout_err), 32'd0);
        idle(1);
        check("tmo_flag", 32'(rc_timeout_err), 32'd1);
        check("tmo_addr", 32'(mem_port_A_address), 32'd7);
        send_word(8'h34, 8'h12, 3'd7);
        @(negedge clk);
        check("tmo_overrun_clear", 32'(rc_overrun_err), 32'd0);
        rc_abort = 1'b1;
        @(negedge clk);
        rc_abort = 1'b0;

        // Overrun: strobe during WRITE is dropped
        start_run();
        send_octet(8'h55);
        idle(11);
        exp_q.push_back({3'd7, 8'h66, 8'h55});
        @(negedge clk);
        rx_dataH  = 8'h66;
        rx_validH = 1'b1;
        @(negedge clk);
        rx_dataH  = 8'hEE;
        @(negedge clk);
        rx_validH = 1'b0;
        check("ovr_flag", 32'(rc_overrun_err), 32'd1);
        idle(3);
        send_word(8'h77, 8'h88, 3'd6);
        idle(4);
        send_word(8'hAA, 8'hBB, 3'd5);
        idle(4);

        // Abort after three words
        rc_abort = 1'b1;
        @(negedge clk);
        rc_abort = 1'b0;
        check("abort_idle", 32'(rc_state), 32'd0);
        send_octet(8'h99);
        done_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            done_seen = done_seen | rc_done;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);
        check("abort_queue_empty", exp_q.size(), 32'd0);
        start_run();
        check("restart_errs", {rc_timeout_err, rc_overrun_err}, 32'd0);

        // Reset mid-word
        send_octet(8'h11);
        idle(2);
        rst_l = 1'b0;
        #1;
        check("midrst_outputs", {ack_rc_run, rc_done, mem_port_A_we, mem_port_A_address, mem_port_A_din,
                                 rc_timeout_err, rc_overrun_err}, 32'd0);
        @(negedge clk);
        rst_l = 1'b1;
        send_octet(8'h42);
        idle(5);
        check("midrst_idle", 32'(rc_state), 32'd0);
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
